// File: rtl/dense_seq_ctrl_pkg.sv
// dense_seq_ctrl_pkg
//   Shared types and constants for the dense-layer sequencer.
//   N_LEN / F_LEN : fixed-point word width and fraction bits (the dense datapath format).
//   CHUNK         : width of the dot-product unit (elements per issue).
//   tag_t         : per-issue tag travelling alongside the SRAM + dot-product pipeline.
//   addr_w()      : address width helper that never returns zero, so a single-entry
//                   space still gets a 1-bit port.
package dense_seq_ctrl_pkg;

  localparam int N_LEN = 16;
  localparam int F_LEN = 8;
  localparam int CHUNK = 6;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dense_tag_pipe.sv
// dense_tag_pipe
//   D-deep shift register carrying {valid, first, last} for every issued chunk, so the
//   sequencer knows on which cycle a dot-product result belongs to which chunk.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//     tag_i      : tag presented in the issue cycle
//     tag_o      : the same tag, D cycles later
module dense_tag_pipe
  import dense_seq_ctrl_pkg::*;
#(
  parameter int D = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < D; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign tag_o = stage_q[D-1];

endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl
//   Sequencer for one fully-connected layer: y[j] = sum_i x[i]*w[j][i].
//   Walks x / w memories in 6-wide chunks, accumulates the chunk results coming back
//   from the external dot-product unit, and presents each neuron on a valid/ready port.
//   Optional bias: define DENSE_SEQ_BIAS_EN to add b_addr / b_data; the first chunk of
//   each neuron then starts from b_data instead of zero.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     start                : pulse, begins a layer pass (ignored while busy)
//     busy                 : high from accepted start until done
//     done                 : one-cycle pulse after the last neuron handshake
//     rd_en, x_addr, w_addr: SRAM read strobe and chunk addresses (w_addr = j*C + c)
//     b_addr, b_data       : bias address / data (DENSE_SEQ_BIAS_EN only)
//     inner_q              : dot-product result, valid D = MEM_LAT+INNER_LAT cycles after rd_en
//     out_valid/out_ready  : output handshake
//     out_idx, out_data    : neuron index j and y[j]
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_ISSUE | one read per cycle, chunks c = 0..C-1 of neuron j
//   S_DRAIN | waiting for the last-tagged result of neuron j
//   S_OUT   | y[j] presented, held until accepted
module dense_seq_ctrl
  import dense_seq_ctrl_pkg::*;
#(
  parameter int N_IN       = 12,
  parameter int N_OUT      = 4,
  parameter int DATA_WIDTH = N_LEN,
  parameter int INNER_LAT  = 3,
  parameter int MEM_LAT    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [addr_w(N_IN/CHUNK)-1:0]         x_addr,
  output logic [addr_w(N_OUT*N_IN/CHUNK)-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]                 inner_q,
`ifdef DENSE_SEQ_BIAS_EN
  output logic [addr_w(N_OUT)-1:0]              b_addr,
  input  logic [DATA_WIDTH-1:0]                 b_data,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [addr_w(N_OUT)-1:0]              out_idx,
  output logic [DATA_WIDTH-1:0]                 out_data
);

  localparam int C  = N_IN / CHUNK;
  localparam int D  = MEM_LAT + INNER_LAT;
  localparam int XW = addr_w(C);
  localparam int WW = addr_w(N_OUT * C);
  localparam int JW = addr_w(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                state_q;
  logic [XW-1:0]         c_q;
  logic [WW-1:0]         w_addr_q;
  logic [JW-1:0]         j_q;
  logic                  rd_en_q;
  logic                  first_q;
  logic                  last_q;
  logic                  done_q;
  logic                  out_valid_q;
  logic                  res_rdy_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] acc_base;
  logic [DATA_WIDTH-1:0] acc_d;
  tag_t                  tag_in;
  tag_t                  tag_out;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = rd_en_q;
    tag_in.first = first_q;
    tag_in.last  = last_q;
  end

  dense_tag_pipe #(
    .D (D)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // The first chunk of a neuron restarts the sum; wrapping add, no saturation.
`ifdef DENSE_SEQ_BIAS_EN
  assign acc_base = tag_out.first ? b_data : acc_q;
`else
  assign acc_base = tag_out.first ? '0 : acc_q;
`endif
  assign acc_d = acc_base + inner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      w_addr_q    <= '0;
      j_q         <= '0;
      rd_en_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_rdy_q   <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;

      if (tag_out.valid) begin
        acc_q <= acc_d;
        if (tag_out.last) begin
          out_data_q <= acc_d;
          res_rdy_q  <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_ISSUE;
            j_q      <= '0;
            c_q      <= '0;
            w_addr_q <= '0;
            rd_en_q  <= 1'b1;
            first_q  <= 1'b1;
            last_q   <= (C == 1);
          end
        end

        S_ISSUE: begin
          if (c_q == XW'(C - 1)) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            c_q      <= c_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
            first_q  <= 1'b0;
            last_q   <= (int'(c_q) + 2 == C);
          end
        end

        S_DRAIN: begin
          if (res_rdy_q) begin
            res_rdy_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == JW'(N_OUT - 1)) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              // w_addr continues linearly: j*C + (C-1) + 1 == (j+1)*C.
              j_q      <= j_q + 1'b1;
              c_q      <= '0;
              w_addr_q <= w_addr_q + 1'b1;
              rd_en_q  <= 1'b1;
              first_q  <= 1'b1;
              last_q   <= (C == 1);
              state_q  <= S_ISSUE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign x_addr    = c_q;
  assign w_addr    = w_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = j_q;
  assign out_data  = out_data_q;
`ifdef DENSE_SEQ_BIAS_EN
  assign b_addr    = j_q;
`endif

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb_dense_seq_ctrl
//   Drives dense_seq_ctrl with random layer data, models the SRAM + dot-product unit
//   as a fixed-delay queue, and compares every accepted neuron against y[j] computed
//   directly from the whole x / w vectors. Bias build: define DENSE_SEQ_BIAS_EN.
module tb_dense_seq_ctrl;
  import dense_seq_ctrl_pkg::*;

  localparam int N_IN  = 12;
  localparam int N_OUT = 2;
  localparam int DW    = N_LEN;
  localparam int C     = N_IN / 6;
  localparam int D     = 1 + 3;
  localparam int XW    = addr_w(C);
  localparam int WW    = addr_w(N_OUT * C);
  localparam int JW    = addr_w(N_OUT);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, out_valid;
  logic [XW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic [DW-1:0] inner_q = '0;
  logic          out_ready = 1'b0;
  logic [JW-1:0] out_idx;
  logic [DW-1:0] out_data;
`ifdef DENSE_SEQ_BIAS_EN
  logic [JW-1:0] b_addr;
  logic [DW-1:0] b_data;
`endif

  int xm [N_IN];
  int wm [N_OUT][N_IN];
  int bm [N_OUT];

`ifdef DENSE_SEQ_BIAS_EN
  assign b_data = DW'(bm[int'(b_addr)]);
`endif

  dense_seq_ctrl #(
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .DATA_WIDTH (DW),
    .INNER_LAT  (3),
    .MEM_LAT    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .inner_q   (inner_q),
`ifdef DENSE_SEQ_BIAS_EN
    .b_addr    (b_addr),
    .b_data    (b_data),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One 6-wide dot product as the external unit would produce it, from chunk addresses.
  function automatic logic [DW-1:0] chunk_dot(input int xa, input int wa);
    int s;
    int flat;
    s = 0;
    for (int k = 0; k < 6; k++) begin
      flat = wa * 6 + k;
      s += (xm[xa * 6 + k] * wm[flat / N_IN][flat % N_IN]) >>> F_LEN;
    end
    return s[DW-1:0];
  endfunction

  // Whole-neuron reference: bias + sum over the full input vector, wrapped to DW bits.
  function automatic logic [DW-1:0] ref_y(input int j);
    int s;
    s = 0;
`ifdef DENSE_SEQ_BIAS_EN
    s = bm[j];
`endif
    for (int i = 0; i < N_IN; i++) s += (xm[i] * wm[j][i]) >>> F_LEN;
    return s[DW-1:0];
  endfunction

  int            cyc = 0;
  int            issue_cnt = 0;
  int            out_cnt = 0;
  int            done_cnt = 0;
  int            first_rd_cyc = 0;
  int            last_hs_cyc = 0;
  int            stall_left = 0;
  bit            seen_valid = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [JW-1:0] held_idx;
  logic [DW-1:0] pq_val [$];
  int            pq_due [$];

  always @(negedge clk) begin
    bit hs;
    int dummy;
    cyc++;
    if (rst_n) begin
      if (rd_en) begin
        pq_val.push_back(chunk_dot(int'(x_addr), int'(w_addr)));
        pq_due.push_back(cyc + D);
        chk("x_addr", x_addr, issue_cnt % C);
        chk("w_addr", w_addr, issue_cnt);
`ifdef DENSE_SEQ_BIAS_EN
        chk("b_addr", b_addr, issue_cnt / C);
`endif
        chk("rd_while_out_valid", out_valid, 0);
        if (issue_cnt == 0) first_rd_cyc = cyc;
        else if (issue_cnt % C == 0) chk("issue_after_hs", cyc - last_hs_cyc, 1);
        issue_cnt++;
      end
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
        inner_q = pq_val.pop_front();
        dummy = pq_due.pop_front();
      end else begin
        inner_q = DW'($urandom);
      end

      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_data);
        chk("hold_idx", out_idx, held_idx);
        chk("stall_rd_en", rd_en, 0);
      end

      if (out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          chk("first_latency", cyc - first_rd_cyc, C + D + 1);
        end
        if (stall_left > 0) begin
          stall_left--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end

      hs        = out_valid && out_ready;
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
      held_idx  = out_idx;
      if (hs) begin
        if (out_cnt >= N_OUT) begin
          chk("extra_output", out_cnt, N_OUT - 1);
        end else begin
          chk("out_idx", out_idx, out_cnt);
          chk("out_data", out_data, ref_y(out_cnt));
        end
        out_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        chk("done_timing", cyc - last_hs_cyc, 1);
        chk("done_after_all", out_cnt, N_OUT);
        done_cnt++;
      end
    end else begin
      hold_prev = 1'b0;
      out_ready = 1'b0;
      inner_q   = '0;
    end
  end

  task automatic clear_pass(input int stall);
    issue_cnt    = 0;
    out_cnt      = 0;
    done_cnt     = 0;
    seen_valid   = 1'b0;
    stall_left   = stall;
    first_rd_cyc = 0;
    last_hs_cyc  = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_pass(input int stall, input bit start_in_drain);
    int k;
    clear_pass(stall);
    pulse_start();
    chk("busy_after_start", busy, 1);
    if (start_in_drain) begin
      for (k = 0; k < 100 && rd_en; k++) @(negedge clk);
      chk("in_drain", {busy, rd_en, out_valid}, 3'b100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (k = 0; k < 2000 && done_cnt == 0; k++) @(negedge clk);
    chk("pass_timeout", done_cnt > 0, 1);
    repeat (5) @(negedge clk);
    chk("one_done", done_cnt, 1);
    chk("n_outputs", out_cnt, N_OUT);
    chk("idle_after_pass", busy, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_IN; i++) xm[i] = int'($urandom_range(0, 1023)) - 512;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) wm[j][i] = int'($urandom_range(0, 1023)) - 512;
      bm[j] = int'($urandom_range(0, 2047)) - 1024;
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < N_IN; i++) xm[i] = 256;
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) wm[j][i] = 128;
    bm[0] = 256;
    bm[1] = -512;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
`ifdef DENSE_SEQ_BIAS_EN
    chk("reset_outputs", {busy, done, rd_en, out_valid, out_idx, out_data, x_addr, w_addr, b_addr}, 0);
`else
    chk("reset_outputs", {busy, done, rd_en, out_valid, out_idx, out_data, x_addr, w_addr}, 0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // x = 1.0, w = 0.5 everywhere
    run_pass(0, 1'b0);

    // neuron 1 weights -0.25, neuron 0 held off for 5 cycles
    for (int i = 0; i < N_IN; i++) wm[1][i] = -64;
    run_pass(5, 1'b0);

    fill_random();
    run_pass(0, 1'b1);

    for (int p = 0; p < 6; p++) begin
      fill_random();
      run_pass(int'($urandom_range(0, 4)), 1'b0);
    end

    // abort during neuron 1 issue
    fill_random();
    clear_pass(0);
    pulse_start();
    for (k = 0; k < 200 && issue_cnt <= C; k++) @(negedge clk);
    chk("reached_neuron1", issue_cnt > C, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, rd_en, out_valid, out_idx, out_data}, 0);
    pq_val.delete();
    pq_due.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy, 0);

    fill_random();
    run_pass(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_seq_ctrl.md
Name: dense_seq_ctrl

Overview:
- Sequencer for one fully-connected layer built on the 6-wide, 3-cycle pipelined dot-product unit (dense_inner_6).
- Computes y[j] = sum over i of x[i]*w[j][i] for j = 0..N_OUT-1.
- Walks x and w memories in chunks of 6, accumulates the per-chunk partial sums, and hands each finished neuron out over a valid/ready port.
- Sits between the layer's SRAM read ports and the activation / next-layer stage.

Parameters:
- N_IN, 12, input vector length; must be a multiple of 6.
- N_OUT, 4, number of output neurons.
- DATA_WIDTH, `N_LEN, fixed-point word width.
- INNER_LAT, 3, pipeline latency of the dot-product unit.
- MEM_LAT, 1, SRAM read latency.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a layer pass
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last neuron handshake
- rd_en  out  1  SRAM read strobe
- x_addr  out  clog2(N_IN/6)  x chunk address
- w_addr  out  clog2(N_OUT*N_IN/6)  w chunk address, equal to j*(N_IN/6)+c
- inner_q  in  DATA_WIDTH  dense_inner_6 result
- out_valid  out  1  y word valid
- out_ready  in  1  downstream accept
- out_idx  out  clog2(N_OUT)  neuron index j of out_data
- out_data  out  DATA_WIDTH  y[j]

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and accumulator cleared, tag pipe cleared. Reset asserted mid-pass aborts the pass; no done pulse is issued.
- FSM states:
  - IDLE: start -> ISSUE with j=0, c=0.
  - ISSUE: rd_en=1 every cycle with c=0..C-1 (C=N_IN/6). After c=C-1 -> DRAIN.
  - DRAIN: waits for the last-tagged result. Then out_valid=1 -> OUT.
  - OUT: holds out_data and out_idx stable until out_valid&&out_ready. Then, if j<N_OUT-1: j++, c=0 -> ISSUE; otherwise done=1 -> IDLE.
- start outside IDLE is ignored.
- Tag pipe: shift register of depth D=MEM_LAT+INNER_LAT carrying {valid, first, last} per issue. inner_q is sampled on the cycle its tag exits, D cycles after the rd_en cycle.
- Accumulate: acc <= (first ? 0 : acc) + inner_q. Addition is wrapping at DATA_WIDTH bits, with no saturation, matching the dot-product unit.
- On the last tag, out_data <= final sum, registered. out_valid rises the following cycle.
- Latency per neuron: C issue cycles + D + 1 cycles to out_valid. A zero-wait handshake adds 1 cycle before the next issue.
- No overlap between neurons. Issue never starts while OUT is pending, so backpressure cannot overflow the pipeline.
- busy = (state != IDLE).
- N_OUT=1 is legal: done follows the single handshake.

Optional Feature:
- Macro DENSE_SEQ_BIAS_EN.
- When defined:
  - adds output port b_addr (clog2(N_OUT)), driven to j during ISSUE.
  - adds input port b_data (DATA_WIDTH), sampled with the first-tagged result.
  - the first-chunk update becomes acc <= b_data + inner_q.
- When undefined: neither port exists and the first chunk starts from 0.

Decomposition:
- consts_train.vh supplies N_LEN and F_LEN.
- The FSM state encoding (IDLE/ISSUE/DRAIN/OUT) is local localparams.
- One natural sub-module, dense_tag_pipe: a parameterised D-deep valid/first/last shift register with asynchronous reset.
- dense_inner_6 and the SRAMs are instantiated outside this block.

Test Plan:
- Basic pass: N_IN=12, N_OUT=2, x=1.0, w=0.5, start pulse -> out (0, 6.0), then (1, 6.0); done one cycle after the second handshake; first out_valid exactly C+D+1=7 cycles after the first rd_en.
- Backpressure: hold out_ready=0 for 5 cycles on neuron 0 -> out_data/out_idx stable, rd_en stays 0, neuron 1 issue begins the cycle after acceptance.
- Distinct weights: w[1][*]=-0.25 -> y[1]=-3.0 (two's complement); verifies sign and that acc clears on the first chunk.
- start while busy, pulsed during DRAIN -> ignored; exactly N_OUT outputs and one done.
- Reset mid-pass: assert rst_n=0 during the ISSUE of neuron 1 -> all outputs 0 immediately; a subsequent start yields a clean correct pass.
- DENSE_SEQ_BIAS_EN: b=[1.0, -2.0] with the basic stimulus -> y=(7.0, 4.0); b_addr tracks j.
